// File: rtl/bk_subtractor_pipe.sv
// Three-stage Brent-Kung subtractor: out = ina - inb - bin, formed as ina + ~inb + ~bin.
// S1 bit g/p, S2 up-sweep block terms, S3 down-sweep carries into the output register.
module bk_subtractor_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int LOG   = $clog2(WIDTH);
  localparam int NODES = 2*WIDTH - 1;

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bk_subtractor_pipe: WIDTH must be a power of two in 8..64");
  end

  // Full tree is flattened level by level: node (l,k) lives at off(l)+k.
  function automatic int off(input int l);
    return 2*WIDTH - ((2*WIDTH) >> l);
  endfunction

  // Only even-indexed nodes (plus the root) feed the down-sweep; they are packed
  // at eoff(l)+k/2, with the root landing at WIDTH-1.
  function automatic int eoff(input int l);
    return WIDTH - (WIDTH >> l);
  endfunction

  function automatic int lowbit(input int j);
    int t;
    t = LOG;
    for (int b = LOG - 1; b >= 0; b--)
      if (((j >> b) & 1) != 0) t = b;
    return t;
  endfunction

  // ---------------- handshake ----------------
  logic [3:1] r_vld;
  logic       w_ld1, w_ld2, w_ld3;

  assign w_ld3     = !r_vld[3] || out_ready;
  assign w_ld2     = !r_vld[2] || w_ld3;
  assign w_ld1     = !r_vld[1] || w_ld2;
  assign in_ready  = w_ld1;
  assign out_valid = r_vld[3];

  // ---------------- S1: bit generate/propagate ----------------
  logic [WIDTH-1:0] r1_g, r1_p;
  logic             r1_c0, r1_sa, r1_sb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r1_g  <= '0;
      r1_p  <= '0;
      r1_c0 <= 1'b0;
      r1_sa <= 1'b0;
      r1_sb <= 1'b0;
    end else begin
      if (w_ld1) r_vld[1] <= in_valid;
      if (w_ld2) r_vld[2] <= r_vld[1];
      if (w_ld3) r_vld[3] <= r_vld[2];
      if (w_ld1 && in_valid) begin
        r1_g  <= ina & ~inb;
        r1_p  <= ina ^ ~inb;
        r1_c0 <= ~bin;
        r1_sa <= ina[WIDTH-1];
        r1_sb <= ~inb[WIDTH-1];
      end
    end
  end

  // ---------------- S2: up-sweep ----------------
  logic [NODES-1:0] w_tg, w_tp;
  logic [WIDTH-1:0] w_up_g, w_up_p;

  always_comb begin
    w_tg = '0;
    w_tp = '0;
    w_tg[WIDTH-1:0] = r1_g;
    w_tp[WIDTH-1:0] = r1_p;
    for (int l = 1; l <= LOG; l++)
      for (int k = 0; k < (WIDTH >> l); k++) begin
        w_tg[off(l)+k] = w_tg[off(l-1)+2*k+1] |
                         (w_tp[off(l-1)+2*k+1] & w_tg[off(l-1)+2*k]);
        w_tp[off(l)+k] = w_tp[off(l-1)+2*k+1] & w_tp[off(l-1)+2*k];
      end
    w_up_g = '0;
    w_up_p = '0;
    for (int l = 0; l < LOG; l++)
      for (int m = 0; m < (WIDTH >> (l + 1)); m++) begin
        w_up_g[eoff(l)+m] = w_tg[off(l)+2*m];
        w_up_p[eoff(l)+m] = w_tp[off(l)+2*m];
      end
    w_up_g[WIDTH-1] = w_tg[NODES-1];
    w_up_p[WIDTH-1] = w_tp[NODES-1];
  end

  logic [WIDTH-1:0] r2_p, r2_g_blk, r2_p_blk;
  logic             r2_c0, r2_sa, r2_sb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_p     <= '0;
      r2_g_blk <= '0;
      r2_p_blk <= '0;
      r2_c0    <= 1'b0;
      r2_sa    <= 1'b0;
      r2_sb    <= 1'b0;
    end else if (w_ld2 && r_vld[1]) begin
      r2_p     <= r1_p;
      r2_g_blk <= w_up_g;
      r2_p_blk <= w_up_p;
      r2_c0    <= r1_c0;
      r2_sa    <= r1_sa;
      r2_sb    <= r1_sb;
    end
  end

  // ---------------- S3: down-sweep ----------------
  // c[j] comes from the even node ending at bit j-1, chained from c[j - lowbit(j)].
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_diff;
  logic             w_ovf;

  always_comb begin
    w_c    = '0;
    w_c[0] = r2_c0;
    for (int j = 1; j <= WIDTH; j++)
      w_c[j] = r2_g_blk[eoff(lowbit(j)) + ((j >> lowbit(j)) - 1) / 2] |
               (r2_p_blk[eoff(lowbit(j)) + ((j >> lowbit(j)) - 1) / 2] &
                w_c[j - (1 << lowbit(j))]);
    w_diff = r2_p ^ w_c[WIDTH-1:0];
    // Same as c[W]^c[W-1]: like-signed operands giving a result of the other sign.
    w_ovf  = (r2_sa == r2_sb) && (w_diff[WIDTH-1] != r2_sa);
  end

  logic [WIDTH-1:0] r3_out;
  logic             r3_bout, r3_ovf, r3_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_out  <= '0;
      r3_bout <= 1'b0;
      r3_ovf  <= 1'b0;
      r3_zero <= 1'b0;
    end else if (w_ld3 && r_vld[2]) begin
      r3_out  <= w_diff;
      r3_bout <= ~w_c[WIDTH];
      r3_ovf  <= w_ovf;
      r3_zero <= ~|w_diff;
    end
  end

  assign out  = r3_out;
  assign bout = r3_bout;
  assign ovf  = r3_ovf;
  assign zero = r3_zero;

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Bench for bk_subtractor_pipe: vector table, backpressure, throughput and reset
// sequences, with an arithmetic reference model and in-order scoreboard.
module tb_bk_subtractor_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
  logic [W-1:0] ina, inb, out;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  always #5 clk = ~clk;

  bk_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .bout(bout), .ovf(ovf), .zero(zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  typedef struct packed {
    logic [W-1:0] d;
    logic         b, o, z;
  } res_t;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    res_t   r;
    longint sa, sb, sd, mx, mn;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sd  = sa - sb - (bi ? 64'sd1 : 64'sd0);
    mx  = (longint'(1) <<< (W - 1)) - 1;
    mn  = -(longint'(1) <<< (W - 1));
    r.d = a - b - W'(bi);
    r.b = ({1'b0, a} < ({1'b0, b} + (W+1)'(bi)));
    r.o = (sd > mx) || (sd < mn);
    r.z = (r.d == '0);
    return r;
  endfunction

  // Scoreboard, sampled mid-cycle.
  res_t        sb_q[$];
  res_t        sb_e;
  logic        hold_v = 1'b0;
  logic [63:0] held;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("sb_hold", {out, bout, ovf, zero}, held);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_spurious: result %0h with nothing outstanding", out);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_result", {out, bout, ovf, zero}, {sb_e.d, sb_e.b, sb_e.o, sb_e.z});
        end
        n_out++;
      end
      hold_v = out_valid && !out_ready;
      held   = 64'({out, bout, ovf, zero});
      if (in_valid && in_ready) sb_q.push_back(model(ina, inb, bin));
    end
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo, ov, z;
  } vec_t;

  vec_t tbl[9];

  // Single beat on an empty pipe; called at posedge+1.
  task automatic run_vec(input vec_t v, input int n);
    ina = v.a; inb = v.b; bin = v.bi; in_valid = 1'b1; out_ready = 1'b1;
    #1 check($sformatf("vec%0d_in_ready", n), in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 check($sformatf("vec%0d_lat2", n), out_valid, 0);
    @(posedge clk); #1;
    check($sformatf("vec%0d_valid", n), out_valid, 1);
    check($sformatf("vec%0d_out", n), out, v.d);
    check($sformatf("vec%0d_bout", n), bout, v.bo);
    check($sformatf("vec%0d_ovf", n), ovf, v.ov);
    check($sformatf("vec%0d_zero", n), zero, v.z);
    @(posedge clk); #1 check($sformatf("vec%0d_one_cycle", n), out_valid, 0);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20 && (sb_q.size() > 0 || out_valid); c++) begin
      @(posedge clk); #1;
    end
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, cyc, n0;
    tbl[0] = '{a:32'd5,          b:32'd3,          bi:1'b0, d:32'h00000002, bo:1'b0, ov:1'b0, z:1'b0};
    tbl[1] = '{a:32'h00000000,   b:32'h00000001,   bi:1'b0, d:32'hFFFFFFFF, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[2] = '{a:32'h00010000,   b:32'h00000001,   bi:1'b0, d:32'h0000FFFF, bo:1'b0, ov:1'b0, z:1'b0};
    tbl[3] = '{a:32'h80000000,   b:32'h00000001,   bi:1'b0, d:32'h7FFFFFFF, bo:1'b0, ov:1'b1, z:1'b0};
    tbl[4] = '{a:32'd10,         b:32'd9,          bi:1'b1, d:32'h00000000, bo:1'b0, ov:1'b0, z:1'b1};
    tbl[5] = '{a:32'd7,          b:32'd7,          bi:1'b1, d:32'hFFFFFFFF, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[6] = '{a:32'h7FFFFFFF,   b:32'hFFFFFFFF,   bi:1'b0, d:32'h80000000, bo:1'b1, ov:1'b1, z:1'b0};
    tbl[7] = '{a:32'h00000000,   b:32'h00000000,   bi:1'b1, d:32'hFFFFFFFF, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[8] = '{a:32'hFFFFFFFF,   b:32'hFFFFFFFF,   bi:1'b0, d:32'h00000000, bo:1'b0, ov:1'b0, z:1'b1};

    rst = 1'b1; in_valid = 1'b0; ina = '0; inb = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_flags", {bout, ovf, zero}, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Backpressure: 6 beats, out_ready held low for the first 8 cycles.
    n0 = n_out; k = 0; cyc = 0;
    while (k < 6 && cyc < 40) begin
      ina = W'(k + 100); inb = W'(k); bin = 1'b0; in_valid = 1'b1;
      out_ready = (cyc >= 8);
      #1;
      if (cyc == 3) check("bp_accepted3", k, 3);
      if (cyc >= 3 && cyc < 8) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_out", out, 100);
      end
      if (in_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_sent", k, 6);
    drain("bp_drain");
    check("bp_all_out", n_out - n0, 6);

    // Full throughput with random operands.
    n0 = n_out;
    for (int i = 0; i < 64; i++) begin
      ina = $urandom;
      inb = (i % 8 == 0) ? ina : $urandom;
      bin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      #1 check("tp_in_ready", in_ready, 1);
      if (i >= 3) check("tp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("tp_drain");
    check("tp_all_out", n_out - n0, 64);

    // Reset with three beats in flight, plus an offered beat during reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ina = $urandom; inb = $urandom; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("rf_pre_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b1; ina = 32'd7; inb = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rf_out_valid", out_valid, 0);
    check("rf_out", out, 0);
    check("rf_flags", {bout, ovf, zero}, 0);
    check("rf_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 check("rf_no_stale", out_valid, 0);
    end
    run_vec('{a:32'd7, b:32'd7, bi:1'b0, d:32'h0, bo:1'b0, ov:1'b0, z:1'b1}, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
